// File: rtl/vx_ifetch_tag_stage.sv
// vx_ifetch_tag_stage
//    Instruction-fetch tag stage between the warp scheduler and the I-cache.
//    Each accepted fetch request is issued to the cache tagged with a free
//    in-flight slot; the request metadata waits in a small RAM until the cache
//    returns that tag (in any order). It is then re-joined with the instruction
//    word and presented to decode through a registered valid/ready output.
//
//    Optional build macro: IFETCH_PERF_EN
//       Adds perf_stall_cycles (cycles a request waited on a full slot table,
//       saturating) and perf_max_inflight (peak number of slots in flight).

// Checker: a cache response must name a slot that is currently in flight.
module vx_ifetch_tag_stage_chk (
   input  logic clk,
   input  logic reset,
   input  logic i_rsp_fire,
   input  logic i_tag_live
);

   // Flag any accepted cache response whose tag has no outstanding request.
   always @(posedge clk) begin
      if (!reset && i_rsp_fire) begin
         assert (i_tag_live)
         else $error("vx_ifetch_tag_stage: icache response tag not in flight");
      end
   end

endmodule

module vx_ifetch_tag_stage #(
   parameter  int NUM_WARPS   = 4,
   parameter  int NUM_THREADS = 4,
   parameter  int UUID_BITS   = 44,
   parameter  int TAG_DEPTH   = 4,
   localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int TAG_BITS    = $clog2(TAG_DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   // scheduler request
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [NW_BITS-1:0]     req_wid,
   input  logic [NUM_THREADS-1:0] req_tmask,
   input  logic [31:0]            req_pc,
   input  logic [UUID_BITS-1:0]   req_uuid,
   // icache request
   output logic                   icache_req_valid,
   input  logic                   icache_req_ready,
   output logic [29:0]            icache_req_addr,
   output logic [TAG_BITS-1:0]    icache_req_tag,
   // icache response
   input  logic                   icache_rsp_valid,
   output logic                   icache_rsp_ready,
   input  logic [TAG_BITS-1:0]    icache_rsp_tag,
   input  logic [31:0]            icache_rsp_data,
   // decode response
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [NW_BITS-1:0]     rsp_wid,
   output logic [NUM_THREADS-1:0] rsp_tmask,
   output logic [31:0]            rsp_pc,
   output logic [UUID_BITS-1:0]   rsp_uuid,
   output logic [31:0]            rsp_instr,
   output logic                   busy
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]            perf_stall_cycles,
   output logic [TAG_BITS:0]      perf_max_inflight
`endif
);

   localparam int META_W = NW_BITS + NUM_THREADS + 32 + UUID_BITS;

   // Lowest-index free slot; slot 0 when none is free (unused while full).
   function automatic logic [TAG_BITS-1:0] lowest_clear(input logic [TAG_DEPTH-1:0] used);
      logic [TAG_BITS-1:0] idx;
      idx = '0;
      for (int i = TAG_DEPTH - 1; i >= 0; i--) begin
         if (!used[i]) begin
            idx = TAG_BITS'(i);
         end
      end
      return idx;
   endfunction

   logic [TAG_DEPTH-1:0]  r_slot_used;
   logic [META_W-1:0]     r_meta_ram [TAG_DEPTH];
   logic                  r_rsp_valid;
   logic [META_W-1:0]     r_rsp_meta;
   logic [31:0]           r_rsp_instr;

   logic                  w_full;
   logic [TAG_BITS-1:0]   w_alloc_idx;
   logic                  w_req_fire;
   logic                  w_rsp_fire;
   logic                  w_tag_live;
   logic [TAG_DEPTH-1:0]  w_set_mask;
   logic [TAG_DEPTH-1:0]  w_clr_mask;
   logic [META_W-1:0]     w_rsp_meta;

   // Allocation: both handshakes pass straight through, gated only by full.
   assign w_full           = &r_slot_used;
   assign w_alloc_idx      = lowest_clear(r_slot_used);
   assign icache_req_valid = req_valid & ~w_full;
   assign req_ready        = icache_req_ready & ~w_full;
   assign icache_req_addr  = req_pc[31:2];
   assign icache_req_tag   = w_alloc_idx;
   assign w_req_fire       = req_valid & req_ready;

   // Response: accept whenever the output register is empty or draining.
   assign icache_rsp_ready = ~r_rsp_valid | rsp_ready;
   assign w_rsp_fire       = icache_rsp_valid & icache_rsp_ready;
   assign w_tag_live       = r_slot_used[icache_rsp_tag];
   assign w_rsp_meta       = r_meta_ram[icache_rsp_tag];

   // A stray tag (slot not in flight) must leave slot_used untouched.
   assign w_set_mask = {{(TAG_DEPTH-1){1'b0}}, w_req_fire} << w_alloc_idx;
   assign w_clr_mask = {{(TAG_DEPTH-1){1'b0}}, w_rsp_fire & w_tag_live} << icache_rsp_tag;

   // Slot table: mark a slot on issue, release it when its response is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot_used <= '0;
      end else begin
         r_slot_used <= (r_slot_used | w_set_mask) & ~w_clr_mask;
      end
   end

   // Metadata RAM: capture request fields into the allocated slot (not reset).
   always_ff @(posedge clk) begin
      if (w_req_fire) begin
         r_meta_ram[w_alloc_idx] <= {req_wid, req_tmask, req_pc, req_uuid};
      end
   end

   // Output register: load joined response, or empty it once decode takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_meta  <= '0;
         r_rsp_instr <= 32'd0;
      end else if (w_rsp_fire) begin
         r_rsp_valid <= 1'b1;
         r_rsp_meta  <= w_rsp_meta;
         r_rsp_instr <= icache_rsp_data;
      end else if (r_rsp_valid & rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_wid   = r_rsp_meta[META_W-1 -: NW_BITS];
   assign rsp_tmask = r_rsp_meta[32 + UUID_BITS +: NUM_THREADS];
   assign rsp_pc    = r_rsp_meta[UUID_BITS +: 32];
   assign rsp_uuid  = r_rsp_meta[0 +: UUID_BITS];
   assign rsp_instr = r_rsp_instr;
   assign busy      = (|r_slot_used) | r_rsp_valid;

`ifdef IFETCH_PERF_EN
   // Number of set bits in the slot table.
   function automatic logic [TAG_BITS:0] popcount(input logic [TAG_DEPTH-1:0] v);
      logic [TAG_BITS:0] n;
      n = '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
         n = n + {{TAG_BITS{1'b0}}, v[i]};
      end
      return n;
   endfunction

   logic [31:0]       r_perf_stall;
   logic [TAG_BITS:0] r_perf_max;
   logic [TAG_BITS:0] w_inflight;

   assign w_inflight = popcount(r_slot_used);

   // Perf: count full-table stalls (saturating) and track peak occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_stall <= 32'd0;
         r_perf_max   <= '0;
      end else begin
         if (req_valid & w_full & ~(&r_perf_stall)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (w_inflight > r_perf_max) begin
            r_perf_max <= w_inflight;
         end
      end
   end

   assign perf_stall_cycles = r_perf_stall;
   assign perf_max_inflight = r_perf_max;
`endif

   vx_ifetch_tag_stage_chk u_chk (
      .clk        (clk),
      .reset      (reset),
      .i_rsp_fire (w_rsp_fire),
      .i_tag_live (w_tag_live)
   );

endmodule

// File: tb/tb_vx_ifetch_tag_stage.sv
// Bench for vx_ifetch_tag_stage: directed fetch scenarios, a behavioural model
// of the slot table / output register checked every negedge, plus literal
// expectations at key points.
module tb_vx_ifetch_tag_stage;

   logic        clk;
   logic        reset;
   logic        req_valid, req_ready;
   logic [1:0]  req_wid;
   logic [3:0]  req_tmask;
   logic [31:0] req_pc;
   logic [43:0] req_uuid;
   logic        icache_req_valid, icache_req_ready;
   logic [29:0] icache_req_addr;
   logic [1:0]  icache_req_tag;
   logic        icache_rsp_valid, icache_rsp_ready;
   logic [1:0]  icache_rsp_tag;
   logic [31:0] icache_rsp_data;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_wid;
   logic [3:0]  rsp_tmask;
   logic [31:0] rsp_pc;
   logic [43:0] rsp_uuid;
   logic [31:0] rsp_instr;
   logic        busy;

   vx_ifetch_tag_stage dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
      .req_tmask(req_tmask), .req_pc(req_pc), .req_uuid(req_uuid),
      .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
      .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
      .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
      .icache_rsp_tag(icache_rsp_tag), .icache_rsp_data(icache_rsp_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid),
      .rsp_tmask(rsp_tmask), .rsp_pc(rsp_pc), .rsp_uuid(rsp_uuid),
      .rsp_instr(rsp_instr), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [1:0]  wid;
      logic [3:0]  tmask;
      logic [31:0] pc;
      logic [43:0] uuid;
   } meta_t;

   bit          m_inflight [4];
   meta_t       m_meta     [4];
   bit          m_out_v;
   meta_t       m_out;
   logic [31:0] m_out_instr;
   int          m_slot;
   bit          m_req_go, m_rsp_go;

   function automatic int m_free_slot();
      for (int i = 0; i < 4; i++) if (!m_inflight[i]) return i;
      return -1;
   endfunction

   function automatic bit m_any_inflight();
      for (int i = 0; i < 4; i++) if (m_inflight[i]) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      m_out_v     = 1'b0;
      m_out       = '0;
      m_out_instr = 32'd0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            for (int i = 0; i < 4; i++) m_inflight[i] = 1'b0;
            m_out_v     = 1'b0;
            m_out       = '0;
            m_out_instr = 32'd0;
         end else begin
            m_slot   = m_free_slot();
            m_req_go = req_valid && icache_req_ready && (m_slot >= 0);
            m_rsp_go = icache_rsp_valid && (!m_out_v || rsp_ready);
            if (m_rsp_go) begin
               m_out       = m_meta[icache_rsp_tag];
               m_out_instr = icache_rsp_data;
               m_out_v     = 1'b1;
               m_inflight[icache_rsp_tag] = 1'b0;
            end else if (m_out_v && rsp_ready) begin
               m_out_v = 1'b0;
            end
            if (m_req_go) begin
               m_meta[m_slot]     = '{req_wid, req_tmask, req_pc, req_uuid};
               m_inflight[m_slot] = 1'b1;
            end
         end
      end
   end

   // Compare process: every negedge, DUT vs model.
   initial begin
      forever begin
         @(negedge clk);
         chk("m_req_ready", req_ready, icache_req_ready && (m_free_slot() >= 0));
         chk("m_icache_req_valid", icache_req_valid, req_valid && (m_free_slot() >= 0));
         if (req_valid && (m_free_slot() >= 0)) begin
            chk("m_icache_req_tag", icache_req_tag, m_free_slot());
            chk("m_icache_req_addr", icache_req_addr, req_pc >> 2);
         end
         chk("m_icache_rsp_ready", icache_rsp_ready, !m_out_v || rsp_ready);
         chk("m_rsp_valid", rsp_valid, m_out_v);
         chk("m_rsp_wid", rsp_wid, m_out.wid);
         chk("m_rsp_tmask", rsp_tmask, m_out.tmask);
         chk("m_rsp_pc", rsp_pc, m_out.pc);
         chk("m_rsp_uuid", rsp_uuid, m_out.uuid);
         chk("m_rsp_instr", rsp_instr, m_out_instr);
         chk("m_busy", busy, m_any_inflight() || m_out_v);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] w, input logic [3:0] tm,
                          input logic [31:0] pc, input logic [43:0] u);
      req_valid = 1'b1; req_wid = w; req_tmask = tm; req_pc = pc; req_uuid = u;
   endtask

   task automatic issue(input logic [1:0] w, input logic [3:0] tm, input logic [31:0] pc,
                        input logic [43:0] u, input int exp_tag);
      set_req(w, tm, pc, u);
      #1;
      chk("issue_ready", req_ready, 1'b1);
      chk("issue_tag", icache_req_tag, exp_tag);
      step();
      req_valid = 1'b0;
   endtask

   task automatic cache_rsp(input logic [1:0] t, input logic [31:0] d);
      icache_rsp_valid = 1'b1; icache_rsp_tag = t; icache_rsp_data = d;
      #1;
      for (int n = 0; n < 20 && !icache_rsp_ready; n++) step();
      if (!icache_rsp_ready) begin
         n_total++;
         $display("FAIL cache_rsp_wait: icache_rsp_ready got 0 expected 1 within 20 cycles");
      end
      step();
      icache_rsp_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b0; req_valid = 1'b0; req_wid = 2'd0; req_tmask = 4'd0;
      req_pc = 32'd0; req_uuid = 44'd0; icache_req_ready = 1'b1;
      icache_rsp_valid = 1'b0; icache_rsp_tag = 2'd0; icache_rsp_data = 32'd0;
      rsp_ready = 1'b1;
      #1 reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      #1;
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);

      // Single fetch
      set_req(2'd2, 4'b0011, 32'h8000_0010, 44'd5);
      #1;
      chk("t1_icache_req_valid", icache_req_valid, 1'b1);
      chk("t1_addr", icache_req_addr, 30'h2000_0004);
      chk("t1_tag", icache_req_tag, 2'd0);
      step();
      req_valid = 1'b0;
      repeat (2) step();
      cache_rsp(2'd0, 32'h0000_0013);
      chk("t1_rsp_valid", rsp_valid, 1'b1);
      chk("t1_rsp_wid", rsp_wid, 2'd2);
      chk("t1_rsp_tmask", rsp_tmask, 4'b0011);
      chk("t1_rsp_pc", rsp_pc, 32'h8000_0010);
      chk("t1_rsp_uuid", rsp_uuid, 44'd5);
      chk("t1_rsp_instr", rsp_instr, 32'h0000_0013);
      chk("t1_busy_during", busy, 1'b1);
      step();
      chk("t1_busy_after", busy, 1'b0);

      // Fill: four issue, fifth stalls until tag 1 returns
      for (int k = 0; k < 4; k++)
         issue(2'(k), 4'hF, 32'h0000_1000 + 32'(4 * k), 44'(100 + k), k);
      set_req(2'd1, 4'h1, 32'h0000_2000, 44'd104);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("t2_full_req_ready", req_ready, 1'b0);
         chk("t2_full_icache_req_valid", icache_req_valid, 1'b0);
         step();
      end
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd1; icache_rsp_data = 32'h1111_0001;
      #1;
      chk("t2_still_full", req_ready, 1'b0);
      step();
      icache_rsp_valid = 1'b0;
      #1;
      chk("t2_freed_ready", req_ready, 1'b1);
      chk("t2_freed_tag", icache_req_tag, 2'd1);
      chk("t2_rsp_uuid", rsp_uuid, 44'd101);
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) cache_rsp(2'(k), 32'hA000_0000 + 32'(k));
      chk("t2_tag1_reissued_uuid", rsp_uuid, 44'd103);
      step();

      // Out of order returns 2,0,1
      issue(2'd0, 4'h1, 32'h0000_3000, 44'd301, 0);
      issue(2'd1, 4'h2, 32'h0000_3004, 44'd302, 1);
      issue(2'd2, 4'h4, 32'h0000_3008, 44'd303, 2);
      cache_rsp(2'd2, 32'hB000_0002);
      chk("t3_first_uuid", rsp_uuid, 44'd303);
      cache_rsp(2'd0, 32'hB000_0000);
      chk("t3_second_uuid", rsp_uuid, 44'd301);
      cache_rsp(2'd1, 32'hB000_0001);
      chk("t3_third_uuid", rsp_uuid, 44'd302);
      chk("t3_third_pc", rsp_pc, 32'h0000_3004);
      step();

      // Back-pressure
      rsp_ready = 1'b0;
      issue(2'd3, 4'h8, 32'h0000_4000, 44'd401, 0);
      issue(2'd3, 4'h9, 32'h0000_4004, 44'd402, 1);
      cache_rsp(2'd0, 32'hC000_0000);
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd1; icache_rsp_data = 32'hC000_0001;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("t4_icache_rsp_ready", icache_rsp_ready, 1'b0);
         chk("t4_hold_valid", rsp_valid, 1'b1);
         chk("t4_hold_uuid", rsp_uuid, 44'd401);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("t4_release_ready", icache_rsp_ready, 1'b1);
      step();
      icache_rsp_valid = 1'b0;
      chk("t4_second_valid", rsp_valid, 1'b1);
      chk("t4_second_uuid", rsp_uuid, 44'd402);
      chk("t4_second_instr", rsp_instr, 32'hC000_0001);
      step();
      chk("t4_no_dup", rsp_valid, 1'b0);

      // Simultaneous alloc (slot 3) and free (slot 0)
      issue(2'd0, 4'h3, 32'h0000_5000, 44'd500, 0);
      issue(2'd1, 4'h3, 32'h0000_5004, 44'd501, 1);
      issue(2'd2, 4'h3, 32'h0000_5008, 44'd502, 2);
      set_req(2'd3, 4'h3, 32'h0000_500C, 44'd503);
      icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd0; icache_rsp_data = 32'hD000_0000;
      #1;
      chk("t5_alloc_tag", icache_req_tag, 2'd3);
      chk("t5_both_ready", {req_ready, icache_rsp_ready}, 2'b11);
      step();
      icache_rsp_valid = 1'b0;
      set_req(2'd0, 4'h5, 32'h0000_5010, 44'd504);
      #1;
      chk("t5_next_tag", icache_req_tag, 2'd0);
      chk("t5_next_ready", req_ready, 1'b1);
      chk("t5_rsp_uuid", rsp_uuid, 44'd500);
      step();
      req_valid = 1'b0;
      #1;
      chk("t5_full", req_ready, 1'b0);

      // Async reset mid-cycle with three slots in flight and rsp pending
      rsp_ready = 1'b0;
      cache_rsp(2'd1, 32'hE000_0001);
      chk("t6_pre_valid", rsp_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_rsp_valid", rsp_valid, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_req_ready", req_ready, 1'b1);
      chk("t6_rst_uuid", rsp_uuid, 44'd0);
      step();
      step();
      reset = 1'b0;
      rsp_ready = 1'b1;
      issue(2'd1, 4'h7, 32'h0000_6000, 44'd600, 0);
      cache_rsp(2'd0, 32'hF000_0000);
      chk("t6_post_uuid", rsp_uuid, 44'd600);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
